// File: rtl/vga_pkg.sv
// Shared constants, phase encoding and phase decode for the VGA timing generator.
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2048;

  // 640x480 @ 60 Hz
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIX_DIV  = 4;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  function automatic phase_e phase_of(input logic [COORD_W-1:0] cnt,
                                      input int n_active, input int n_fp, input int n_sync);
    int c;
    c = int'(cnt);
    if (c < n_active)                    return PH_ACTIVE;
    else if (c < n_active + n_fp)        return PH_FRONT;
    else if (c < n_active + n_fp + n_sync) return PH_SYNC;
    else                                 return PH_BACK;
  endfunction

endpackage

// File: rtl/pix_div.sv
// Pixel clock-enable divider: strobes pix_en_o for one clk out of every PIX_DIV.
module pix_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en_o
);

  localparam int CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  assign pix_en_o = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, syncs and markers, all registered and coincident.
// Define VGA_PIX_DIV_EN to advance one pixel every PIX_DIV clocks instead of every clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_DIV  = DEF_PIX_DIV
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed %0d", MAX_TOTAL);
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_DIV < 1) begin : g_bad_param
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end

  logic pix_en_w;

`ifdef VGA_PIX_DIV_EN
  if (PIX_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be >= 2 with the divider enabled");
  end

  pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_en_o (pix_en_w)
  );
`else
  // Combinational so the very first clk edge after release already advances to (0,0).
  assign pix_en_w = ~rst;
`endif

  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  phase_e             h_ph_d, v_ph_d;
  logic               hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

  always_comb begin
    // NOTE: every variable gets a value on every path before any conditional update,
    // otherwise synthesis infers a latch to hold the old value.
    h_d = (h_q == H_LAST) ? '0 : h_q + COORD_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
    h_ph_d = phase_of(h_d, H_ACTIVE, H_FP, H_SYNC);
    v_ph_d = phase_of(v_d, V_ACTIVE, V_FP, V_SYNC);
  end

  // Flags decode the next count so they change on the same edge as the counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // independent of statement order.
    if (rst) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en_w) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= (h_ph_d != PH_SYNC);
      vsync_q       <= (v_ph_d != PH_SYNC);
      active_q      <= (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
      line_start_q  <= (h_d == '0);
      frame_start_q <= (h_d == '0) && (v_d == '0);
    end
  end

  assign pix_en      = pix_en_w;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Video timing generator for the display path. Produces the raster scan coordinates that drive the sprite hit-test stage's pixel-coordinate inputs (`o`/`p`, 11 bits each). It also produces the sync, blanking and frame/line markers needed by the pixel output stage. All outputs are registered and mutually coincident, so the combinational hit-test result lines up with the same pixel.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `PIX_DIV`, 4: clk cycles per pixel; used only when the divider is compiled in
- `clk` in 1: system clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `pix_en` out 1: pixel-advance strobe; every output below updates only on a cycle where this is 1
- `hcount` out 11: current pixel column, 0..H_TOTAL-1
- `vcount` out 11: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `active` out 1: high when `hcount`<H_ACTIVE and `vcount`<V_ACTIVE
- `line_start` out 1: high for the pixel period where `hcount`==0
- `frame_start` out 1: high for the pixel period where `hcount`==0 and `vcount`==0

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration check: both totals must be ≤2048, and every parameter must be ≥1.
- Horizontal counter, on each `pix_en`:
  - `hcount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vcount` advances.
- Vertical counter: `vcount` wraps from V_TOTAL-1 to 0.
- Horizontal phases, decoded from `hcount`:
  - ACTIVE: [0, H_ACTIVE-1]
  - FRONT: [H_ACTIVE, H_ACTIVE+H_FP-1]
  - SYNC: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - BACK: the remainder
  - Vertical phases use the same scheme; V SYNC is lines 490..491.
- `hsync`=0 only in horizontal SYNC; `vsync`=0 only in vertical SYNC, for the whole line including its horizontal blanking.
- Flag registers load from the next-count decode in the same edge as the counters. No output lags `hcount`/`vcount`.
- Reset state is "last pixel of previous frame":
  - `hcount`=H_TOTAL-1, `vcount`=V_TOTAL-1
  - `hsync`=1, `vsync`=1, `active`=0, `line_start`=0, `frame_start`=0, `pix_en`=0
- First `pix_en` after reset release moves to (0,0) with `active`=1, `line_start`=1, `frame_start`=1.
- Reset asserted mid-frame forces the reset state immediately, without waiting for `clk`. Scanning restarts at (0,0) on the first `pix_en` after release.
- Counter arithmetic is unsigned 11-bit. Compare against parameter-derived constants; never rely on natural overflow.

## Timing
- Latency: one `clk` edge from a `pix_en` cycle to the updated outputs.
- Outputs hold for PIX_DIV clks between updates, so `line_start`/`frame_start` last one pixel period, not one clk.
- No handshake: the block free-runs and downstream samples on `pix_en`.
- Frame period: H_TOTAL×V_TOTAL pixel periods = 420000.

## Configuration
- Macro: `VGA_PIX_DIV_EN`.
- Defined:
  - A mod-PIX_DIV divider runs; it resets to 0.
  - `pix_en`=1 on the cycle the divider equals PIX_DIV-1, giving the first strobe on the PIX_DIV-th clk edge after release.
  - PIX_DIV must be ≥2.
- Undefined:
  - `pix_en` is 0 in reset and 1 on every clk after release.
  - One pixel per clk; PIX_DIV is ignored.

## Structure
- Package `vga_pkg`:
  - `COORD_W`=11
  - default 640×480@60 timing constants
  - phase enum `{PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}`
- Sub-module `pix_div`: the clock-enable divider, instantiated only under `VGA_PIX_DIV_EN`.
- Counters, phase decode and flag registers live in `vga_timing_gen`.

## Test plan
- Reset release, macro off: on the 1st clk, (0,0) with `active`=1, `frame_start`=1, `line_start`=1, `hsync`=`vsync`=1.
- Horizontal sweep:
  - `hsync` falls at `hcount` 655→656 and rises at 751→752.
  - At 799→0, `vcount` increments and `line_start`=1 for exactly one pixel.
- Vertical sweep:
  - `vsync` is low for lines 490–491 only.
  - (799,524)→(0,0) raises `frame_start`; the next `frame_start` comes 420000 pixels later.
- Active count: exactly 307200 `active` pixels per frame, none with `hcount`≥640 or `vcount`≥480.
- Macro on, PIX_DIV=4:
  - `pix_en` every 4th clk and counters hold between strobes.
  - Frame period is 1680000 clk.
- Assert `rst` asynchronously at (300,200):
  - Outputs go to (799,524) with `hsync`=`vsync`=1 and `active`=0, without a clk edge.
  - After release, scanning resumes at (0,0).
